// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//  Groups the value/control inputs and the display outputs of seg7_scan_driver.
//  master : the producer of the value (drives value/load/dp/blank_all, observes display)
//  slave  : the scan driver (consumes value/control, drives seg/sel/frame_start)
//  Signals:
//   value[15:0]  hex value, nibble k shown on digit k
//   load         1-cycle capture strobe into the pending register
//   dp[3:0]      per-digit decimal point
//   blank_all    force display dark while scanning continues
//   seg[7:0]     segments a..g,dp on bits 7..0, active-high
//   sel[3:0]     digit select, active-low
//   frame_start  pulse when digit 0 SHOW begins
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic        blank_all;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        frame_start;

  modport master (output value, load, dp, blank_all,
                  input  seg, sel, frame_start);
  modport slave  (input  value, load, dp, blank_all,
                  output seg, sel, frame_start);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//  Scans a 4-digit multiplexed 7-segment display from a double-buffered 16-bit hex value.
//  Each digit is lit for SCAN_DIV cycles, separated by BLANK_CYCLES of all-dark to avoid
//  ghosting. The displayed value (active) only changes at the frame commit, i.e. when
//  digit 0 SHOW begins, so a frame never mixes old and new data.
//  Ports:
//   clock  in  system clock, posedge
//   reset  in  asynchronous active-high reset
//   bus    slave modport of seg7_scan_driver_if (value/load/dp/blank_all in,
//          seg/sel/frame_start out, all outputs registered)
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 32,
  parameter int BLANK_CYCLES = 2,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  digit_q;
  logic [15:0] pending_q, active_q;
  logic [7:0]  seg_q;
  logic [3:0]  sel_q;
  logic        fs_q;
  logic        dp_q;     // dp bit latched at SHOW entry for the lit digit

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'hFC; 4'h1: decode = 8'h60; 4'h2: decode = 8'hDA; 4'h3: decode = 8'hF2;
      4'h4: decode = 8'h66; 4'h5: decode = 8'hB6; 4'h6: decode = 8'hBE; 4'h7: decode = 8'hE0;
      4'h8: decode = 8'hFE; 4'h9: decode = 8'hF6; 4'hA: decode = 8'hEE; 4'hB: decode = 8'h3E;
      4'hC: decode = 8'h9C; 4'hD: decode = 8'h7A; 4'hE: decode = 8'h9E; default: decode = 8'h8E;
    endcase
  endfunction

  // A digit is a leading zero when it and every more-significant nibble are zero.
  function automatic logic lz(input logic [15:0] a, input logic [1:0] d);
    case (d)
      2'd1:    lz = (a[15:4]  == 12'h000);
      2'd2:    lz = (a[15:8]  == 8'h00);
      2'd3:    lz = (a[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] seg_for(input logic [15:0] a, input logic [1:0] d,
                                         input logic dpb);
    if (LZ_SUPPRESS && lz(a, d)) seg_for = {7'b0, dpb};
    else                         seg_for = decode(a[{d, 2'b00} +: 4]) | {7'b0, dpb};
  endfunction

  function automatic logic [3:0] sel_for(input logic [1:0] d);
    sel_for = ~(4'b0001 << d);
  endfunction

  // Entry into SHOW: the new digit, and the data it decodes (fresh pending on commit).
  logic [1:0]  digit_d;
  logic        commit;
  logic [15:0] act_d;
  logic        dp_d;
  assign digit_d = digit_q + 2'd1;
  assign commit  = (digit_d == 2'd0);
  assign act_d   = commit ? pending_q : active_q;
  assign dp_d    = bus.dp[digit_d];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      digit_q   <= 2'd3;
      pending_q <= '0;
      active_q  <= '0;
      seg_q     <= 8'h00;
      sel_q     <= 4'hF;
      fs_q      <= 1'b0;
      dp_q      <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (bus.load) pending_q <= bus.value;
      case (state_q)
        BLANK: begin
          seg_q <= 8'h00;
          sel_q <= 4'hF;
          if (cnt_q == BLANK_LAST) begin
            cnt_q   <= '0;
            state_q <= SHOW;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            if (commit) begin
              active_q <= pending_q;
              fs_q     <= 1'b1;
            end
            if (!bus.blank_all) begin
              seg_q <= seg_for(act_d, digit_d, dp_d);
              sel_q <= sel_for(digit_d);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin // SHOW
          if (cnt_q == SHOW_LAST) begin
            cnt_q   <= '0;
            state_q <= BLANK;
            seg_q   <= 8'h00;
            sel_q   <= 4'hF;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            // Re-registered every SHOW edge so a blank_all release restores output.
            if (bus.blank_all) begin
              seg_q <= 8'h00;
              sel_q <= 4'hF;
            end else begin
              seg_q <= seg_for(active_q, digit_q, dp_q);
              sel_q <= sel_for(digit_q);
            end
          end
        end
      endcase
    end
  end

  assign bus.seg         = seg_q;
  assign bus.sel         = sel_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//  Directed bench for seg7_scan_driver at SCAN_DIV=32, BLANK_CYCLES=2. A second instance with
//  LZ_SUPPRESS=0 shares all inputs. Sampling is 1 time unit after each posedge; "offset t"
//  below means t edges after the frame_start edge (digit k lights at offset 34*k).
module tb_seg7_scan_driver;
  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errs    = 0;

  seg7_scan_driver_if bus ();
  seg7_scan_driver_if bus2 ();

  seg7_scan_driver #(.SCAN_DIV(32), .BLANK_CYCLES(2), .LZ_SUPPRESS(1'b1))
    dut  (.clock(clock), .reset(reset), .bus(bus));
  seg7_scan_driver #(.SCAN_DIV(32), .BLANK_CYCLES(2), .LZ_SUPPRESS(1'b0))
    dut2 (.clock(clock), .reset(reset), .bus(bus2));

  assign bus2.value     = bus.value;
  assign bus2.load      = bus.load;
  assign bus2.dp        = bus.dp;
  assign bus2.blank_all = bus.blank_all;

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (bus.frame_start !== 1'b1 && n < 300);
    chk("frame_wait", {7'b0, bus.frame_start}, 8'h01);
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    step(1);
    bus.load  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.value = 16'h0; bus.load = 1'b0; bus.dp = 4'h0; bus.blank_all = 1'b0;

    // 1: reset hold, release timing, digit lit 32 cycles then 2 dark
    step(3);
    chk("rst_seg", bus.seg, 8'h00);
    chk("rst_sel", {4'h0, bus.sel}, 8'h0F);
    chk("rst_fs", {7'b0, bus.frame_start}, 8'h00);
    reset = 1'b0;
    step(1);
    chk("rel1_sel", {4'h0, bus.sel}, 8'h0F);
    step(1);
    chk("rel2_sel", {4'h0, bus.sel}, 8'h0E);
    chk("rel2_seg", bus.seg, 8'hFC);
    chk("rel2_fs", {7'b0, bus.frame_start}, 8'h01);
    step(1);
    chk("fs_pulse", {7'b0, bus.frame_start}, 8'h00);
    step(30);                                    // offset 31
    chk("d0_last_lit", {4'h0, bus.sel}, 8'h0E);
    step(1);                                     // offset 32
    chk("gap1_sel", {4'h0, bus.sel}, 8'h0F);
    chk("gap1_seg", bus.seg, 8'h00);
    step(1);
    chk("gap2_sel", {4'h0, bus.sel}, 8'h0F);
    step(1);                                     // offset 34: digit 1, suppressed zero
    chk("d1_sup_sel", {4'h0, bus.sel}, 8'h0D);
    chk("d1_sup_seg", bus.seg, 8'h00);

    // 2: 12AF shown next frame
    do_load(16'h12AF);
    wait_frame();
    chk("t2_d0_seg", bus.seg, 8'h8E);
    chk("t2_d0_sel", {4'h0, bus.sel}, 8'h0E);
    step(34);
    chk("t2_d1_seg", bus.seg, 8'hEE);
    chk("t2_d1_sel", {4'h0, bus.sel}, 8'h0D);
    step(34);
    chk("t2_d2_seg", bus.seg, 8'hDA);
    chk("t2_d2_sel", {4'h0, bus.sel}, 8'h0B);
    step(34);
    chk("t2_d3_seg", bus.seg, 8'h60);
    chk("t2_d3_sel", {4'h0, bus.sel}, 8'h07);
    step(34);                                    // 136 after previous frame_start
    chk("t2_period_fs", {7'b0, bus.frame_start}, 8'h01);
    chk("t2_period_seg", bus.seg, 8'h8E);

    // 3: leading-zero suppression, and LZ_SUPPRESS=0 instance
    do_load(16'h0005);
    wait_frame();
    chk("t3_d0_seg", bus.seg, 8'hB6);
    step(34);
    chk("t3_d1_seg", bus.seg, 8'h00);
    chk("t3_d1_sel", {4'h0, bus.sel}, 8'h0D);
    chk("t3_nolz_d1_seg", bus2.seg, 8'hFC);
    step(34);
    chk("t3_d2_seg", bus.seg, 8'h00);
    chk("t3_nolz_d2_seg", bus2.seg, 8'hFC);
    step(34);
    chk("t3_d3_seg", bus.seg, 8'h00);
    chk("t3_d3_sel", {4'h0, bus.sel}, 8'h07);
    chk("t3_nolz_d3_seg", bus2.seg, 8'hFC);
    do_load(16'h0000);
    wait_frame();
    chk("t3_zero_d0_seg", bus.seg, 8'hFC);
    step(34);
    chk("t3_zero_d1_seg", bus.seg, 8'h00);

    // 4: mid-frame load waits for commit; load in the commit cycle lands one frame later
    do_load(16'h2222);
    wait_frame();
    chk("t4_d0_seg", bus.seg, 8'hDA);
    step(68);
    chk("t4_d2_seg", bus.seg, 8'hDA);
    do_load(16'h1111);                           // captured during d2 SHOW
    step(33);                                    // offset 102
    chk("t4_d3_old_seg", bus.seg, 8'hDA);
    chk("t4_d3_sel", {4'h0, bus.sel}, 8'h07);
    step(34);
    chk("t4_new_fs", {7'b0, bus.frame_start}, 8'h01);
    chk("t4_new_d0", bus.seg, 8'h60);
    step(34);
    chk("t4_new_d1", bus.seg, 8'h60);
    step(34);
    chk("t4_new_d2", bus.seg, 8'h60);
    step(34);
    chk("t4_new_d3", bus.seg, 8'h60);
    step(33);                                    // offset 135, commit edge next
    do_load(16'h3333);
    chk("t4_commit_fs", {7'b0, bus.frame_start}, 8'h01);
    chk("t4_commit_old", bus.seg, 8'h60);
    step(136);
    chk("t4_late_fs", {7'b0, bus.frame_start}, 8'h01);
    chk("t4_late_seg", bus.seg, 8'hF2);

    // 5: decimal points and blank_all
    bus.dp = 4'b0100;
    do_load(16'h0300);
    wait_frame();
    chk("t5_d0_seg", bus.seg, 8'hFC);
    step(34);
    chk("t5_d1_seg", bus.seg, 8'hFC);
    step(34);
    chk("t5_d2_dp_seg", bus.seg, 8'hF3);
    chk("t5_d2_sel", {4'h0, bus.sel}, 8'h0B);
    bus.dp = 4'b1100;
    step(34);
    chk("t5_d3_supdp_seg", bus.seg, 8'h01);
    chk("t5_d3_sel", {4'h0, bus.sel}, 8'h07);
    bus.dp = 4'b0000;
    step(34);
    chk("t5_fs", {7'b0, bus.frame_start}, 8'h01);
    step(40);                                    // offset 40, mid d1
    chk("t5_d1_pre", {4'h0, bus.sel}, 8'h0D);
    bus.blank_all = 1'b1;
    step(1);
    chk("t5_blank_seg", bus.seg, 8'h00);
    chk("t5_blank_sel", {4'h0, bus.sel}, 8'h0F);
    step(9);
    chk("t5_blank_end_sel", {4'h0, bus.sel}, 8'h0F);
    bus.blank_all = 1'b0;
    step(1);
    chk("t5_restore_sel", {4'h0, bus.sel}, 8'h0D);
    chk("t5_restore_seg", bus.seg, 8'hFC);
    step(85);
    chk("t5_timing_fs", {7'b0, bus.frame_start}, 8'h01);

    // 6: asynchronous reset mid d2 SHOW
    step(70);
    chk("t6_d2_sel", {4'h0, bus.sel}, 8'h0B);
    chk("t6_d2_seg", bus.seg, 8'hF2);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_seg", bus.seg, 8'h00);
    chk("t6_async_sel", {4'h0, bus.sel}, 8'h0F);
    step(1);
    reset = 1'b0;
    step(1);
    chk("t6_rel1_sel", {4'h0, bus.sel}, 8'h0F);
    step(1);
    chk("t6_rel2_sel", {4'h0, bus.sel}, 8'h0E);
    chk("t6_rel2_seg", bus.seg, 8'hFC);
    chk("t6_rel2_fs", {7'b0, bus.frame_start}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
